axi_mm_ram_sink: RTL and testbench
==================================

Name: axi_mm_ram_sink

Overview:
- Responder (sink end) of the team's simple memory-mapped bus (addr/wr/rd/wr_dat, returning rd_dat/rd_dat_val/wait_rq).
- Fronts a single-port RAM through a RAM source port (a/en/we/re/d/q).
- Gives host/config logic word-addressed access to an on-chip RAM.
- Clears the RAM after reset, holds off the master with wait_rq while busy, and flags out-of-range accesses.

Parameters:
- D_BITS, 64, bus data width and RAM word width.
- A_BITS, 8, bus address width (word address).
- RAM_DEPTH, 16, RAM words; RAM address width RA_BITS = $clog2(RAM_DEPTH).
- RAM_LAT, 2, RAM read latency in cycles (>=1): q is valid RAM_LAT cycles after the re strobe.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_addr  in  A_BITS  bus word address.
- i_wr_dat  in  D_BITS  write data.
- i_wr  in  1  write request.
- i_rd  in  1  read request.
- o_rd_dat  out  D_BITS  read data.
- o_rd_dat_val  out  1  read data valid, one-cycle pulse.
- o_wait_rq  out  1  master must hold its request while high.
- o_err  out  1  one-cycle pulse on an out-of-range access.
- o_init_done  out  1  high once the RAM clear has completed.
- o_ram_a  out  RA_BITS  RAM address.
- o_ram_en  out  1  RAM enable.
- o_ram_we  out  1  RAM write strobe.
- o_ram_re  out  1  RAM read strobe.
- o_ram_d  out  D_BITS  RAM write data.
- i_ram_q  in  D_BITS  RAM read data.

Behaviour:
- One clock, i_clk. Reset is synchronous, active-low on i_rst_n, sampled on the rising edge of i_clk.
- Reset values:
  - state = INIT (IDLE if the optional feature is compiled out);
  - o_rd_dat = 0, o_rd_dat_val = 0, o_err = 0, o_init_done = 0 (1 without the feature);
  - clear counter = 0.
- RAM strobes (en/we/re) are forced to 0 while i_rst_n = 0.
- o_wait_rq = 1 in INIT, RD_ISSUE and RD_WAIT; 0 in IDLE. It is decoded from the state register only.
- Acceptance: a request is accepted on a cycle where (i_rd | i_wr) = 1 and o_wait_rq = 0. The master deasserts after acceptance.
- INIT:
  - Drives en = we = 1, d = 0, a = counter, one word per cycle for addresses 0..RAM_DEPTH-1.
  - After the last word (RAM_DEPTH cycles), goes to IDLE and sets o_init_done = 1 (sticky until reset).
- IDLE, write only, in range (i_addr < RAM_DEPTH):
  - Drives en = we = 1, a = i_addr[RA_BITS-1:0], d = i_wr_dat combinationally in the same cycle.
  - Stays in IDLE, so back-to-back writes run one per cycle.
- IDLE, read only, in range, accepted at cycle T:
  - Drives en = re = 1, a = i_addr combinationally; goes to RD_WAIT.
  - At T+RAM_LAT, i_ram_q is registered into o_rd_dat.
  - At T+RAM_LAT+1: o_rd_dat_val = 1 and state = IDLE, so a new request can be accepted in that same cycle.
  - o_rd_dat holds its value until the next read returns.
- IDLE, i_wr and i_rd both high:
  - Both are accepted; the write is performed at T.
  - The read address is latched and the block goes to RD_ISSUE.
  - RD_ISSUE issues the read at T+1 and goes to RD_WAIT; o_rd_dat_val arrives at T+RAM_LAT+2.
  - Read-after-write to the same address returns the new data.
- Out of range (i_addr >= RAM_DEPTH):
  - No RAM strobe; o_err pulses at T+1.
  - A read additionally returns o_rd_dat = 0 with o_rd_dat_val at T+1, and the block stays in IDLE.
  - In a simultaneous rd+wr, the range check applies to the single shared address.
- RAM_LAT counting: a down-counter loaded with RAM_LAT when the read is issued; q is captured when the counter reaches 0.
- Reset mid-operation: a pending read is discarded with no o_rd_dat_val, and the clear restarts from address 0.

Optional Feature:
- AXI_MM_RAM_SINK_INIT_EN
- Defined: INIT clear sequence as above; o_init_done rises after RAM_DEPTH cycles.
- Undefined: no INIT state or clear counter; reset goes directly to IDLE, o_init_done is tied to 1, and RAM contents are undefined after reset.

Test Plan:
(D_BITS=64, A_BITS=8, RAM_DEPTH=16, RAM_LAT=2, INIT_EN defined unless noted)
1. Release reset -> o_wait_rq=1 for 16 cycles; RAM writes addresses 0..15 with data 0; then o_init_done=1 and o_wait_rq=0. Reading 0x7 returns 0.
2. Write 0x5 <= 0x1234, then read 0x5 accepted at T -> o_wait_rq=1 for cycles T+1..T+2; o_rd_dat_val=1 at T+3 with o_rd_dat=0x1234.
3. i_wr=i_rd=1, addr 0x3, data 0xAA at T -> RAM write at T, RAM read at T+1; o_rd_dat_val at T+4 with o_rd_dat=0xAA.
4. Read 0x20 at T -> no RAM strobe; o_err=1 and o_rd_dat_val=1 with o_rd_dat=0 at T+1. Write 0x20 -> no o_ram_we; o_err pulse.
5. Assert i_rst_n=0 during RD_WAIT -> no o_rd_dat_val; after release the clear restarts at address 0 and o_init_done=0 until it finishes.
6. Four back-to-back writes to addresses 0..3, then INIT_EN undefined -> o_wait_rq stays 0 and four consecutive o_ram_we pulses. Without INIT_EN, a read is accepted on the first cycle after reset.

Source files
------------

// File: rtl/axi_mm_ram_sink.sv
// Memory-mapped bus responder fronting a single-port RAM with configurable read latency.
// Define AXI_MM_RAM_SINK_INIT_EN to clear the RAM to zero after every reset.
module axi_mm_ram_sink #(
    parameter int D_BITS    = 64,
    parameter int A_BITS    = 8,
    parameter int RAM_DEPTH = 16,
    parameter int RAM_LAT   = 2,
    parameter int RA_BITS   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [A_BITS-1:0]   i_addr,
    input  logic [D_BITS-1:0]   i_wr_dat,
    input  logic                i_wr,
    input  logic                i_rd,
    output logic [D_BITS-1:0]   o_rd_dat,
    output logic                o_rd_dat_val,
    output logic                o_wait_rq,
    output logic                o_err,
    output logic                o_init_done,
    output logic [RA_BITS-1:0]  o_ram_a,
    output logic                o_ram_en,
    output logic                o_ram_we,
    output logic                o_ram_re,
    output logic [D_BITS-1:0]   o_ram_d,
    input  logic [D_BITS-1:0]   i_ram_q
);

    // Handshake: a request (i_rd | i_wr) is taken on any cycle where o_wait_rq is low;
    // the master holds its request while o_wait_rq is high and drops it after acceptance.

    localparam int LC_BITS = $clog2(RAM_LAT + 1);
    localparam logic [A_BITS:0]    DEPTH_A  = (A_BITS + 1)'(RAM_DEPTH);
    localparam logic [LC_BITS-1:0] LAT_LOAD = LC_BITS'(RAM_LAT);

`ifdef AXI_MM_RAM_SINK_INIT_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_INIT     = 2'd3
    } state_t;
    localparam state_t ST_RESET = ST_INIT;
    localparam logic [RA_BITS-1:0] LAST_A = RA_BITS'(RAM_DEPTH - 1);
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2
    } state_t;
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t              state_q, state_d;
    logic [LC_BITS-1:0]  lat_cnt_q, lat_cnt_d;
    logic [LC_BITS-1:0]  lat_dec;
    logic [RA_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic [D_BITS-1:0]   rd_dat_q, rd_dat_d;
    logic                rd_dat_val_q, rd_dat_val_d;
    logic                err_q, err_d;
`ifdef AXI_MM_RAM_SINK_INIT_EN
    logic [RA_BITS-1:0]  clr_cnt_q, clr_cnt_d;
    logic                init_done_q, init_done_d;
`endif

    logic                ram_en, ram_we, ram_re;
    logic [RA_BITS-1:0]  ram_a;
    logic [D_BITS-1:0]   ram_d;
    logic                in_range;
    logic [RA_BITS-1:0]  addr_ra;

    assign in_range = ({1'b0, i_addr} < DEPTH_A);
    assign addr_ra  = i_addr[RA_BITS-1:0];
    assign lat_dec  = lat_cnt_q - LC_BITS'(1);

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        rd_addr_d    = rd_addr_q;
        rd_dat_d     = rd_dat_q;
        rd_dat_val_d = 1'b0;
        err_d        = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_a        = '0;
        ram_d        = '0;
`ifdef AXI_MM_RAM_SINK_INIT_EN
        clr_cnt_d    = clr_cnt_q;
        init_done_d  = init_done_q;
`endif
        case (state_q)
`ifdef AXI_MM_RAM_SINK_INIT_EN
            ST_INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_a     = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + RA_BITS'(1);
                if (clr_cnt_q == LAST_A) begin
                    clr_cnt_d   = '0;
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (i_rd || i_wr) begin
                    if (!in_range) begin
                        // Out-of-range reads still complete, returning zero, so the master never stalls.
                        err_d = 1'b1;
                        if (i_rd) begin
                            rd_dat_d     = '0;
                            rd_dat_val_d = 1'b1;
                        end
                    end else if (i_wr) begin
                        ram_en = 1'b1;
                        ram_we = 1'b1;
                        ram_a  = addr_ra;
                        ram_d  = i_wr_dat;
                        if (i_rd) begin
                            rd_addr_d = addr_ra;
                            state_d   = ST_RD_ISSUE;
                        end
                    end else begin
                        ram_en    = 1'b1;
                        ram_re    = 1'b1;
                        ram_a     = addr_ra;
                        lat_cnt_d = LAT_LOAD;
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_ISSUE: begin
                ram_en    = 1'b1;
                ram_re    = 1'b1;
                ram_a     = rd_addr_q;
                lat_cnt_d = LAT_LOAD;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                lat_cnt_d = lat_dec;
                if (lat_dec == '0) begin
                    rd_dat_d     = i_ram_q;
                    rd_dat_val_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_RESET;
            lat_cnt_q    <= '0;
            rd_addr_q    <= '0;
            rd_dat_q     <= '0;
            rd_dat_val_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef AXI_MM_RAM_SINK_INIT_EN
            clr_cnt_q    <= '0;
            init_done_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            rd_addr_q    <= rd_addr_d;
            rd_dat_q     <= rd_dat_d;
            rd_dat_val_q <= rd_dat_val_d;
            err_q        <= err_d;
`ifdef AXI_MM_RAM_SINK_INIT_EN
            clr_cnt_q    <= clr_cnt_d;
            init_done_q  <= init_done_d;
`endif
        end
    end

    // Strobes are gated by reset so the RAM is never touched while reset is held.
    assign o_ram_en     = ram_en & i_rst_n;
    assign o_ram_we     = ram_we & i_rst_n;
    assign o_ram_re     = ram_re & i_rst_n;
    assign o_ram_a      = ram_a;
    assign o_ram_d      = ram_d;
    assign o_wait_rq    = (state_q != ST_IDLE);
    assign o_rd_dat     = rd_dat_q;
    assign o_rd_dat_val = rd_dat_val_q;
    assign o_err        = err_q;
`ifdef AXI_MM_RAM_SINK_INIT_EN
    assign o_init_done  = init_done_q;
`else
    assign o_init_done  = 1'b1;
`endif

endmodule

// File: tb/tb_axi_mm_ram_sink.sv
// Bench for axi_mm_ram_sink: directed steps plus random traffic against a word-array model.
// Adapts its expectations to whether AXI_MM_RAM_SINK_INIT_EN is defined.
module tb_axi_mm_ram_sink;
  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;
  localparam int RAW   = 4;

`ifdef AXI_MM_RAM_SINK_INIT_EN
  localparam logic RST_DONE = 1'b0;
  localparam logic RST_WAIT = 1'b1;
`else
  localparam logic RST_DONE = 1'b1;
  localparam logic RST_WAIT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            i_rst_n;
  logic [AW-1:0]   i_addr;
  logic [DW-1:0]   i_wr_dat;
  logic            i_wr;
  logic            i_rd;
  logic [DW-1:0]   o_rd_dat;
  logic            o_rd_dat_val;
  logic            o_wait_rq;
  logic            o_err;
  logic            o_init_done;
  logic [RAW-1:0]  o_ram_a;
  logic            o_ram_en;
  logic            o_ram_we;
  logic            o_ram_re;
  logic [DW-1:0]   o_ram_d;
  logic [DW-1:0]   i_ram_q;

  axi_mm_ram_sink #(
    .D_BITS(DW), .A_BITS(AW), .RAM_DEPTH(DEPTH), .RAM_LAT(LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_wr_dat(i_wr_dat),
    .i_wr(i_wr), .i_rd(i_rd), .o_rd_dat(o_rd_dat), .o_rd_dat_val(o_rd_dat_val),
    .o_wait_rq(o_wait_rq), .o_err(o_err), .o_init_done(o_init_done),
    .o_ram_a(o_ram_a), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_re(o_ram_re), .o_ram_d(o_ram_d), .i_ram_q(i_ram_q)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] preload(input int k);
    return 64'hC0DE_5EED_0000_0000 + 64'(k);
  endfunction

  // RAM environment: q appears LAT cycles after a read strobe
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_pipe [LAT];
  logic          preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int k = 0; k < DEPTH; k++) ram_mem[k] <= preload(k);
      preloaded <= 1'b1;
    end else if (o_ram_en && o_ram_we) begin
      ram_mem[o_ram_a] <= o_ram_d;
    end
    ram_pipe[0] <= (o_ram_en && o_ram_re) ? ram_mem[o_ram_a] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 1; k < LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign i_ram_q = ram_pipe[LAT-1];

  // reference model and scoreboard
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            err_cyc_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // read-return and error monitor
  always @(negedge clk) begin
    logic exp_v;
    logic exp_e;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      void'(exp_cyc_q.pop_front());
      void'(exp_q.pop_front());
    end
    while (err_cyc_q.size() > 0 && err_cyc_q[0] < cyc) void'(err_cyc_q.pop_front());
    exp_v = (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc);
    exp_e = (err_cyc_q.size() > 0 && err_cyc_q[0] == cyc);
    chk("rd_dat_val", 64'(o_rd_dat_val), 64'(exp_v));
    if (exp_v) begin
      chk("rd_dat", o_rd_dat, exp_q[0]);
      void'(exp_cyc_q.pop_front());
      void'(exp_q.pop_front());
    end
    chk("err", 64'(o_err), 64'(exp_e));
    if (exp_e) void'(err_cyc_q.pop_front());
  end

  // driver tasks: each starts just after a rising edge, in the cycle it drives
  task automatic apply_reset(input int n);
    i_rst_n = 1'b0;
    i_rd = 1'b0;
    i_wr = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    err_cyc_q.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("rst_en", 64'(o_ram_en), 64'(0));
      chk("rst_we", 64'(o_ram_we), 64'(0));
      chk("rst_re", 64'(o_ram_re), 64'(0));
      if (k > 0) begin
        chk("rst_rd_dat", o_rd_dat, 64'(0));
        chk("rst_init_done", 64'(o_init_done), 64'(RST_DONE));
        chk("rst_wait", 64'(o_wait_rq), 64'(RST_WAIT));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic release_reset();
    i_rst_n = 1'b1;
`ifdef AXI_MM_RAM_SINK_INIT_EN
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("init_wait", 64'(o_wait_rq), 64'(1));
      chk("init_en", 64'(o_ram_en), 64'(1));
      chk("init_we", 64'(o_ram_we), 64'(1));
      chk("init_re", 64'(o_ram_re), 64'(0));
      chk("init_a", 64'(o_ram_a), 64'(k));
      chk("init_d", o_ram_d, 64'(0));
      chk("init_done_low", 64'(o_init_done), 64'(0));
      @(posedge clk); #1;
    end
    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
`endif
    #1;
    chk("init_done", 64'(o_init_done), 64'(1));
    chk("idle_wait", 64'(o_wait_rq), 64'(0));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_wait", 64'(o_wait_rq), 64'(0));
      chk("idle_en", 64'(o_ram_en), 64'(0));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int t;
    t = cyc;
    i_addr = addr; i_wr_dat = data; i_wr = 1'b1; i_rd = 1'b0;
    @(negedge clk);
    chk("wr_accept", 64'(o_wait_rq), 64'(0));
    if (addr < DEPTH) begin
      chk("wr_en", 64'(o_ram_en), 64'(1));
      chk("wr_we", 64'(o_ram_we), 64'(1));
      chk("wr_re", 64'(o_ram_re), 64'(0));
      chk("wr_a", 64'(o_ram_a), 64'(addr));
      chk("wr_d", o_ram_d, data);
      model_mem[addr[RAW-1:0]] = data;
    end else begin
      chk("wr_oor_en", 64'(o_ram_en), 64'(0));
      chk("wr_oor_we", 64'(o_ram_we), 64'(0));
      err_cyc_q.push_back(t + 1);
    end
    @(posedge clk); #1;
    i_wr = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    int t;
    t = cyc;
    i_addr = addr; i_rd = 1'b1; i_wr = 1'b0;
    @(negedge clk);
    chk("rd_accept", 64'(o_wait_rq), 64'(0));
    if (addr < DEPTH) begin
      exp_q.push_back(model_mem[addr[RAW-1:0]]);
      exp_cyc_q.push_back(t + LAT + 1);
      chk("rd_en", 64'(o_ram_en), 64'(1));
      chk("rd_re", 64'(o_ram_re), 64'(1));
      chk("rd_we", 64'(o_ram_we), 64'(0));
      chk("rd_a", 64'(o_ram_a), 64'(addr));
      @(posedge clk); #1;
      i_rd = 1'b0;
      for (int k = 0; k < LAT; k++) begin
        @(negedge clk);
        chk("rd_busy_wait", 64'(o_wait_rq), 64'(1));
        chk("rd_busy_en", 64'(o_ram_en), 64'(0));
        @(posedge clk); #1;
      end
    end else begin
      exp_q.push_back('0);
      exp_cyc_q.push_back(t + 1);
      err_cyc_q.push_back(t + 1);
      chk("rd_oor_en", 64'(o_ram_en), 64'(0));
      chk("rd_oor_re", 64'(o_ram_re), 64'(0));
      @(posedge clk); #1;
      i_rd = 1'b0;
    end
  endtask

  task automatic do_rdwr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int t;
    t = cyc;
    i_addr = addr; i_wr_dat = data; i_wr = 1'b1; i_rd = 1'b1;
    @(negedge clk);
    chk("rw_accept", 64'(o_wait_rq), 64'(0));
    if (addr < DEPTH) begin
      chk("rw_we", 64'(o_ram_we), 64'(1));
      chk("rw_re0", 64'(o_ram_re), 64'(0));
      chk("rw_a", 64'(o_ram_a), 64'(addr));
      chk("rw_d", o_ram_d, data);
      model_mem[addr[RAW-1:0]] = data;
      exp_q.push_back(data);
      exp_cyc_q.push_back(t + LAT + 2);
      @(posedge clk); #1;
      i_wr = 1'b0; i_rd = 1'b0;
      @(negedge clk);
      chk("rw_issue_wait", 64'(o_wait_rq), 64'(1));
      chk("rw_issue_re", 64'(o_ram_re), 64'(1));
      chk("rw_issue_we", 64'(o_ram_we), 64'(0));
      chk("rw_issue_a", 64'(o_ram_a), 64'(addr));
      @(posedge clk); #1;
      for (int k = 0; k < LAT; k++) begin
        @(negedge clk);
        chk("rw_busy_wait", 64'(o_wait_rq), 64'(1));
        chk("rw_busy_en", 64'(o_ram_en), 64'(0));
        @(posedge clk); #1;
      end
    end else begin
      chk("rw_oor_en", 64'(o_ram_en), 64'(0));
      exp_q.push_back('0);
      exp_cyc_q.push_back(t + 1);
      err_cyc_q.push_back(t + 1);
      @(posedge clk); #1;
      i_wr = 1'b0; i_rd = 1'b0;
    end
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    i_addr = '0; i_wr_dat = '0; i_wr = 1'b0; i_rd = 1'b0; i_rst_n = 1'b0;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = preload(k);

    // reset and clear
    apply_reset(4);
    release_reset();
    do_read(8'h07);

    // write then read back, read-after-write in one request
    do_write(8'h05, 64'h1234);
    do_read(8'h05);
    do_rdwr(8'h03, 64'hAA);

    // out-of-range accesses
    do_read(8'h20);
    do_write(8'h20, 64'h5555);
    do_rdwr(8'hFF, 64'h7777);
    do_read(8'h10);
    idle(1);

    // back-to-back writes and chained reads
    for (int k = 0; k < 4; k++) do_write(8'(k), {$urandom, $urandom});
    for (int k = 0; k < 4; k++) do_read(8'(k));

    // reset while a read is outstanding
    i_addr = 8'h09; i_rd = 1'b1;
    @(negedge clk);
    chk("mid_rd_re", 64'(o_ram_re), 64'(1));
    @(posedge clk); #1;
    i_rd = 1'b0;
    apply_reset(3);
    release_reset();
    do_read(8'h09);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(DEPTH, 255)) : 8'($urandom_range(0, DEPTH - 1));
      d = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0: do_write(a, d);
        1: do_read(a);
        default: do_rdwr(a, d);
      endcase
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end

    // full readback
    for (int k = 0; k < DEPTH; k++) do_read(8'(k));
    idle(3);
    chk("rd_queue_drained", 64'(exp_q.size()), 64'(0));
    chk("err_queue_drained", 64'(err_cyc_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
